// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues one 64-bit memory read at a time and
// hands each returned word to decode, honouring decode stalls and branch redirects.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}},
  parameter int                    INSTR_BYTES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  memReadRequest,
  output logic [ADDR_WIDTH-1:0] memReadAddress,
  input  logic                  memReadValid,
  input  logic [63:0]           memReadData,
  input  logic                  fetchStall,
  input  logic                  redirectEnable,
  input  logic [ADDR_WIDTH-1:0] redirectAddress,
  output logic [63:0]           instructionData,
  output logic                  decodeEnable,
  output logic [ADDR_WIDTH-1:0] issuePc
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-3){1'b1}}, 3'b000};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_pending_q, drop_pending_d;
  logic [63:0]           instr_data_q, instr_data_d;
  logic [ADDR_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_s;

  assign redirect_pc_s = redirectAddress & ALIGN_MASK;

  // Next-state logic for the fetch sequencer, PC and the held decode word.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_pending_d = drop_pending_q;
    instr_data_d   = instr_data_q;
    issue_pc_d     = issue_pc_q;
    case (state_q)
      S_REQ: begin
        if (redirectEnable) begin
          pc_d = redirect_pc_s;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memReadValid) begin
          // A response always retires the outstanding read; only fresh, unredirected data is kept.
          if (redirectEnable) begin
            pc_d           = redirect_pc_s;
            drop_pending_d = 1'b0;
            state_d        = S_REQ;
          end else if (drop_pending_q) begin
            drop_pending_d = 1'b0;
            state_d        = S_REQ;
          end else begin
            instr_data_d = memReadData;
            issue_pc_d   = pc_q;
            state_d      = S_ISSUE;
          end
        end else if (redirectEnable) begin
          pc_d           = redirect_pc_s;
          drop_pending_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (redirectEnable) begin
          pc_d    = redirect_pc_s;
          state_d = S_REQ;
        end else if (fetchStall) begin
          state_d = S_ISSUE;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Handshake outputs are decoded from the current state and suppressed during reset.
  always_comb begin
    memReadRequest = 1'b0;
    decodeEnable   = 1'b0;
    if (reset) begin
      memReadRequest = 1'b0;
      decodeEnable   = 1'b0;
    end else begin
      memReadRequest = (state_q == S_REQ) && !redirectEnable;
      decodeEnable   = (state_q == S_ISSUE) && !fetchStall && !redirectEnable;
    end
  end

  assign memReadAddress  = pc_q;
  assign instructionData = instr_data_q;
  assign issuePc         = issue_pc_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      drop_pending_q <= 1'b0;
      instr_data_q   <= 64'd0;
      issue_pc_q     <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      drop_pending_q <= drop_pending_d;
      instr_data_q   <= instr_data_d;
      issue_pc_q     <= issue_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed cycle-by-cycle vector bench for instruction_fetch, plus a second
// instance checking PC wrap from a top-of-memory reset vector.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_vld;
  logic [63:0] mem_data;
  logic        stall;
  logic        redir;
  logic [31:0] redir_addr;
  logic [63:0] instr;
  logic        dec_en;
  logic [31:0] ipc;

  logic        reset1;
  logic        mem_req1;
  logic [31:0] mem_addr1;
  logic        mem_vld1;
  logic [63:0] mem_data1;
  logic [63:0] instr1;
  logic        dec_en1;
  logic [31:0] ipc1;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .INSTR_BYTES(8)) dut (
    .clk(clk), .reset(reset),
    .memReadRequest(mem_req), .memReadAddress(mem_addr),
    .memReadValid(mem_vld), .memReadData(mem_data),
    .fetchStall(stall), .redirectEnable(redir), .redirectAddress(redir_addr),
    .instructionData(instr), .decodeEnable(dec_en), .issuePc(ipc)
  );

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .INSTR_BYTES(8)) dut_wrap (
    .clk(clk), .reset(reset1),
    .memReadRequest(mem_req1), .memReadAddress(mem_addr1),
    .memReadValid(mem_vld1), .memReadData(mem_data1),
    .fetchStall(1'b0), .redirectEnable(1'b0), .redirectAddress(32'h0000_0000),
    .instructionData(instr1), .decodeEnable(dec_en1), .issuePc(ipc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [63:0] rdata;
    logic        stl;
    logic        rdr;
    logic [31:0] raddr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_de;
    logic [63:0] e_data;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] cur_data;
  logic [31:0] cur_pc;

  function automatic logic [63:0] word_at(input logic [31:0] a);
    return {32'hA5A5_0000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Adds one cycle; the held decode word/PC are tracked in cur_data/cur_pc.
  task automatic add(input logic rst, input logic vld, input logic [63:0] rdata,
                     input logic stl, input logic rdr, input logic [31:0] raddr,
                     input logic e_req, input logic [31:0] e_addr, input logic e_de);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rdata = rdata; v.stl = stl; v.rdr = rdr; v.raddr = raddr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_de = e_de;
    v.e_data = cur_data; v.e_pc = cur_pc;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic e_req, input logic [31:0] e_addr, input logic e_de);
    add(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, e_req, e_addr, e_de);
  endtask

  task automatic deliver(input logic [31:0] a);
    add(1'b0, 1'b1, word_at(a), 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cur_data = word_at(a); cur_pc = a;
  endtask

  initial begin
    cur_data = 64'd0; cur_pc = 32'd0;
    // reset state
    add(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    // L=2 fetch of the predicated opcode word at 0x0
    idle(1'b1, 32'h0, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    add(1'b0, 1'b1, 64'hFC00_0000_0000_0012, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cur_data = 64'hFC00_0000_0000_0012; cur_pc = 32'h0;
    idle(1'b0, 32'h0, 1'b1);
    idle(1'b1, 32'h8, 1'b0);
    // reset again, then four back-to-back L=1 fetches
    add(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cur_data = 64'd0; cur_pc = 32'd0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 32'(i * 8), 1'b0);
      deliver(32'(i * 8));
      idle(1'b0, 32'd0, 1'b1);
    end
    // five-cycle stall in ISSUE
    idle(1'b1, 32'h20, 1'b0);
    deliver(32'h20);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b1);
    idle(1'b1, 32'h28, 1'b0);
    // redirect while waiting: returning word is dropped
    add(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 32'h105, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    add(1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(1'b1, 32'h100, 1'b0);
    deliver(32'h100);
    idle(1'b0, 32'd0, 1'b1);
    // redirect coincident with memReadValid
    idle(1'b1, 32'h108, 1'b0);
    add(1'b0, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0, 1'b0);
    idle(1'b1, 32'h200, 1'b0);
    deliver(32'h200);
    // redirect beats stall in ISSUE
    add(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'h307, 1'b0, 32'd0, 1'b0);
    // redirect in REQ suppresses the request
    add(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 32'h40F, 1'b0, 32'd0, 1'b0);
    // stray memReadValid in REQ and ISSUE is ignored
    add(1'b0, 1'b1, 64'h0BAD_0000_0000_0001, 1'b0, 1'b0, 32'd0, 1'b1, 32'h408, 1'b0);
    deliver(32'h408);
    add(1'b0, 1'b1, 64'h0BAD_0000_0000_0002, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b1);
    // reset during WAIT
    idle(1'b1, 32'h410, 1'b0);
    add(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cur_data = 64'd0; cur_pc = 32'd0;
    idle(1'b1, 32'h0, 1'b0);

    reset = 1'b1; mem_vld = 1'b0; mem_data = 64'd0; stall = 1'b0; redir = 1'b0; redir_addr = 32'd0;
    reset1 = 1'b1; mem_vld1 = 1'b0; mem_data1 = 64'd0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; mem_vld = vecs[i].vld; mem_data = vecs[i].rdata;
      stall = vecs[i].stl; redir = vecs[i].rdr; redir_addr = vecs[i].raddr;
      #1;
      chk($sformatf("req[%0d]", i), {63'd0, mem_req}, {63'd0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("addr[%0d]", i), {32'd0, mem_addr}, {32'd0, vecs[i].e_addr});
      chk($sformatf("dec_en[%0d]", i), {63'd0, dec_en}, {63'd0, vecs[i].e_de});
      chk($sformatf("instr[%0d]", i), instr, vecs[i].e_data);
      chk($sformatf("issue_pc[%0d]", i), {32'd0, ipc}, {32'd0, vecs[i].e_pc});
    end

    // PC wrap from 0xFFFFFFF8, then reset during WAIT
    @(negedge clk); reset1 = 1'b0; #1;
    chk("wrap_req0", {63'd0, mem_req1}, 64'd1);
    chk("wrap_addr0", {32'd0, mem_addr1}, 64'h0000_0000_FFFF_FFF8);
    @(negedge clk); mem_vld1 = 1'b1; mem_data1 = 64'h1234_5678_9ABC_DEF0; #1;
    chk("wrap_wait_req", {63'd0, mem_req1}, 64'd0);
    @(negedge clk); mem_vld1 = 1'b0; #1;
    chk("wrap_de", {63'd0, dec_en1}, 64'd1);
    chk("wrap_data", instr1, 64'h1234_5678_9ABC_DEF0);
    chk("wrap_ipc", {32'd0, ipc1}, 64'h0000_0000_FFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap_req1", {63'd0, mem_req1}, 64'd1);
    chk("wrap_addr1", {32'd0, mem_addr1}, 64'd0);
    @(negedge clk); reset1 = 1'b1; #1;
    chk("wrap_rst_req", {63'd0, mem_req1}, 64'd0);
    chk("wrap_rst_de", {63'd0, dec_en1}, 64'd0);
    @(negedge clk); reset1 = 1'b0; #1;
    chk("wrap_rst_addr", {32'd0, mem_addr1}, 64'h0000_0000_FFFF_FFF8);
    chk("wrap_rst_reqv", {63'd0, mem_req1}, 64'd1);
    chk("wrap_rst_data", instr1, 64'd0);
    chk("wrap_rst_ipc", {32'd0, ipc1}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Producer side of the decode interface: fetches 64-bit instruction words from instruction memory and presents each to the decode stage as instructionData, qualified by a single-cycle decodeEnable.
- Owns the program counter (PC) and handles downstream stall and branch redirect.
- Keeps at most one memory read outstanding.

Parameters:
ADDR_WIDTH, 32, PC and memory address width in bits
RESET_PC, 0, PC value loaded on reset (must be 8-byte aligned)
INSTR_BYTES, 8, PC increment per instruction; fixed at 8 for 64-bit words

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
memReadRequest  output  1  one-cycle read request pulse
memReadAddress  output  ADDR_WIDTH  byte address of the read; equals PC
memReadValid  input  1  read data valid, one cycle, at least 1 cycle after the request
memReadData  input  64  instruction word returned by memory
fetchStall  input  1  decode not ready; hold the current instruction
redirectEnable  input  1  branch/jump taken; load redirectAddress
redirectAddress  input  ADDR_WIDTH  new PC; bits [2:0] ignored (forced 0)
instructionData  output  64  instruction word to decode; bits [7:0] = opcode, bits [63:58] = predicate
decodeEnable  output  1  instructionData valid for decode this cycle
issuePc  output  ADDR_WIDTH  PC of the word on instructionData

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=REQ, pc=RESET_PC, dropPending=0, instructionData=0, issuePc=0.
  - decodeEnable=0 and memReadRequest=0 while reset is high.
  - Memory shares the same reset, so no response survives reset.
  - Reset asserted mid-fetch aborts the fetch; the first request after reset is at RESET_PC.
- States:
  - REQ:
    - memReadRequest=1, memReadAddress=pc, then go to WAIT.
    - If redirectEnable is high in REQ: memReadRequest=0, pc<=redirectAddress&~7, stay in REQ.
  - WAIT:
    - On memReadValid with dropPending=0: instructionData<=memReadData, issuePc<=pc, go to ISSUE.
    - On memReadValid with dropPending=1: discard the data, clear dropPending, go to REQ.
    - redirectEnable in WAIT without memReadValid: pc<=new address, dropPending<=1, stay in WAIT.
    - redirectEnable together with memReadValid: data dropped, pc<=new address, go to REQ.
  - ISSUE:
    - decodeEnable = (state==ISSUE) & !fetchStall & !redirectEnable.
    - No stall and no redirect: pc<=pc+8, go to REQ.
    - fetchStall high: stay in ISSUE; instructionData and issuePc held stable; decodeEnable low.
    - redirectEnable (wins over stall): the word is squashed (no decodeEnable), pc<=new address, go to REQ.
- Latency and throughput:
  - Request in cycle t, memReadValid in cycle t+L (L>=1): decodeEnable is high in cycle t+L+1 and the next request is in t+L+2.
  - Unstalled throughput is one instruction per L+2 cycles.
- decodeEnable is high for exactly one cycle per delivered instruction; never high for dropped or squashed words.
- PC arithmetic is modulo 2^ADDR_WIDTH:
  - pc+8 wraps silently, e.g. with ADDR_WIDTH=32, 0xFFFFFFF8 -> 0x00000000.
  - pc[2:0] is always 0.
- memReadValid outside WAIT is a protocol error. It is ignored and does not change state.

Test Plan:
- Reset, then memory with L=2 returning 0xFC00_0000_0000_0012 at 0x0: memReadRequest in cycle 0 with address 0x0; decodeEnable in cycle 3 with instructionData=0xFC00000000000012 (opcode 0x12, predicate 0x3F), issuePc=0; next request in cycle 4 at address 0x8.
- Four back-to-back fetches, L=1: addresses 0x0, 0x8, 0x10, 0x18; decodeEnable pulses exactly every 3 cycles, each one cycle wide.
- fetchStall held for 5 cycles while in ISSUE: decodeEnable low for those cycles, instructionData unchanged; exactly one decodeEnable pulse the cycle fetchStall falls; no new request until after that pulse.
- redirectEnable with redirectAddress=0x105 during WAIT: the returning word is dropped (no decodeEnable); next request at 0x100; the word delivered from 0x100 carries issuePc=0x100.
- redirectEnable in the same cycle as memReadValid, and separately in ISSUE with fetchStall=1: no decodeEnable for the old word in either case; next request at the redirect target.
- RESET_PC=0xFFFFFFF8, ADDR_WIDTH=32: first request at 0xFFFFFFF8, second at 0x00000000. Reset asserted during WAIT: all outputs return to reset values and the next request is at RESET_PC.
